// File: rtl/packet_rx_parser_pkg.sv
// rtl/packet_rx_parser_pkg.sv - shared packet codes, word indices and parser states
package packet_rx_parser_pkg;

    localparam logic [2:0] PT_HEARTBEAT  = 3'b000;
    localparam logic [2:0] PT_INVITATION = 3'b010;
    localparam logic [2:0] PT_INVALID    = 3'b111;

    localparam logic [15:0] BROADCAST_ID = 16'hFFFF;

    localparam logic [3:0] W_TYPE        = 4'd0;
    localparam logic [3:0] W_SOURCE_ID   = 4'd1;
    localparam logic [3:0] W_DEST_ID     = 4'd2;
    localparam logic [3:0] W_SOURCE_HOPS = 4'd3;
    localparam logic [3:0] W_QVALUE      = 4'd4;
    localparam logic [3:0] W_ENERGY      = 4'd5;
    localparam logic [3:0] W_HOPS_CH     = 4'd6;
    localparam logic [3:0] W_CHOSEN_CH   = 4'd7;
    localparam logic [3:0] W_CHECKSUM    = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BODY  = 3'd1,
        S_CHK   = 3'd2,
        S_HOLD  = 3'd3,
        S_FLUSH = 3'd4
    } parserState_e;

    // A packet is ours when addressed to this node or to everyone.
    function automatic logic isForMe(input logic [15:0] dest, input logic [15:0] me);
        return (dest == me) || (dest == BROADCAST_ID);
    endfunction

endpackage

// File: rtl/pkt_checksum.sv
// rtl/pkt_checksum.sv - running XOR accumulator over packet words
// Ports: clk, nrst (async active-low); clear loads dataWord as the first
// term, accumulate XORs dataWord in; match is high when the accumulated
// value equals cmpWord.
module pkt_checksum (
    input  logic        clk,
    input  logic        nrst,
    input  logic        clear,
    input  logic        accumulate,
    input  logic [15:0] dataWord,
    input  logic [15:0] cmpWord,
    output logic        match
);

    logic [15:0] acc;

    // clear is issued with the header word, so it seeds rather than zeroes.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc <= 16'h0000;
        end else if (clear) begin
            acc <= dataWord;
        end else if (accumulate) begin
            acc <= acc ^ dataWord;
        end
    end

    assign match = (acc == cmpWord);

endmodule

// File: rtl/packet_rx_parser.sv
// rtl/packet_rx_parser.sv - word-serial packet parser with destination filter
// Ports: clk, nrst (async active-low); rx_word/rx_valid/rx_last/rx_ready
// input word stream; myNodeID own address; f* parsed fields, iAmDestination,
// pkt_valid held until pkt_ack; pkt_drop one-cycle pulse per dropped packet.
// Build option: PKT_CHECKSUM_EN adds a ninth XOR checksum word.
module packet_rx_parser
    import packet_rx_parser_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic [15:0] rx_word,
    input  logic        rx_valid,
    input  logic        rx_last,
    output logic        rx_ready,
    input  logic [15:0] myNodeID,
    output logic [2:0]  fPacketType,
    output logic [15:0] fSourceID,
    output logic [15:0] fDestinationID,
    output logic [15:0] fSourceHops,
    output logic [15:0] fQValue,
    output logic [15:0] fEnergyLeft,
    output logic [15:0] fHopsFromCH,
    output logic [15:0] fChosenCH,
    output logic        iAmDestination,
    output logic        pkt_valid,
    input  logic        pkt_ack,
    output logic        pkt_drop
);

`ifdef PKT_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = W_CHECKSUM;
`else
    localparam logic [3:0] LAST_IDX = W_CHOSEN_CH;
`endif

    parserState_e state, nextState;
    logic [3:0]   wordCnt;

    logic [2:0]   shType;
    logic [15:0]  shSourceID, shDestinationID, shSourceHops;
    logic [15:0]  shQValue, shEnergyLeft, shHopsFromCH;
    logic [15:0]  commitChosenCH;

    logic xfer, loadHead, loadBody, commitReq, dropReq, publish, ackTaken;

    assign rx_ready = nrst && ((state == S_IDLE) || (state == S_BODY) || (state == S_FLUSH));
    assign xfer     = rx_valid && rx_ready;

`ifdef PKT_CHECKSUM_EN
    logic [15:0] shChosenCH, shChecksum;
    logic        chkMatch;

    pkt_checksum uChecksum (
        .clk        (clk),
        .nrst       (nrst),
        .clear      (loadHead),
        .accumulate (loadBody && (wordCnt < W_CHECKSUM)),
        .dataWord   (rx_word),
        .cmpWord    (shChecksum),
        .match      (chkMatch)
    );

    assign commitChosenCH = shChosenCH;
`else
    // Without a checksum word the commit happens on the w7 transfer itself.
    assign commitChosenCH = rx_word;
`endif

    always_comb begin
        nextState = state;
        loadHead  = 1'b0;
        loadBody  = 1'b0;
        commitReq = 1'b0;
        dropReq   = 1'b0;
        publish   = 1'b0;
        ackTaken  = 1'b0;
        case (state)
            S_IDLE: begin
                if (xfer) begin
                    if (rx_last) begin
                        dropReq = 1'b1;
                    end else begin
                        loadHead  = 1'b1;
                        nextState = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (xfer) begin
                    loadBody = 1'b1;
                    if (wordCnt == LAST_IDX) begin
                        if (rx_last) begin
`ifdef PKT_CHECKSUM_EN
                            nextState = S_CHK;
`else
                            commitReq = 1'b1;
`endif
                        end else begin
                            nextState = S_FLUSH;
                        end
                    end else if (rx_last) begin
                        dropReq = 1'b1;
                    end
                end
            end
            S_CHK: begin
`ifdef PKT_CHECKSUM_EN
                if (chkMatch) begin
                    commitReq = 1'b1;
                end else begin
                    dropReq = 1'b1;
                end
`else
                nextState = S_IDLE;
`endif
            end
            S_HOLD: begin
                if (pkt_ack) begin
                    ackTaken  = 1'b1;
                    nextState = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (xfer && rx_last) begin
                    dropReq = 1'b1;
                end
            end
            default: nextState = S_IDLE;
        endcase

        // An invalid type is only rejected once the packet is otherwise complete.
        if (commitReq) begin
            if (shType == PT_INVALID) begin
                dropReq = 1'b1;
            end else begin
                publish   = 1'b1;
                nextState = S_HOLD;
            end
        end
        if (dropReq) begin
            nextState = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state           <= S_IDLE;
            wordCnt         <= 4'd0;
            shType          <= PT_INVALID;
            shSourceID      <= 16'h0000;
            shDestinationID <= 16'h0000;
            shSourceHops    <= 16'h0000;
            shQValue        <= 16'h0000;
            shEnergyLeft    <= 16'h0000;
            shHopsFromCH    <= 16'h0000;
`ifdef PKT_CHECKSUM_EN
            shChosenCH      <= 16'h0000;
            shChecksum      <= 16'h0000;
`endif
            fPacketType     <= PT_INVALID;
            fSourceID       <= 16'hFFFF;
            fDestinationID  <= 16'hFFFF;
            fSourceHops     <= 16'hFFFF;
            fQValue         <= 16'h0000;
            fEnergyLeft     <= 16'h0000;
            fHopsFromCH     <= 16'hFFFF;
            fChosenCH       <= 16'h0000;
            iAmDestination  <= 1'b0;
            pkt_valid       <= 1'b0;
            pkt_drop        <= 1'b0;
        end else begin
            state    <= nextState;
            pkt_drop <= dropReq;

            if (loadHead) begin
                shType  <= rx_word[15:13];
                wordCnt <= 4'd1;
            end

            if (loadBody) begin
                wordCnt <= wordCnt + 4'd1;
                case (wordCnt)
                    W_SOURCE_ID:   shSourceID      <= rx_word;
                    W_DEST_ID:     shDestinationID <= rx_word;
                    W_SOURCE_HOPS: shSourceHops    <= rx_word;
                    W_QVALUE:      shQValue        <= rx_word;
                    W_ENERGY:      shEnergyLeft    <= rx_word;
                    W_HOPS_CH:     shHopsFromCH    <= rx_word;
`ifdef PKT_CHECKSUM_EN
                    W_CHOSEN_CH:   shChosenCH      <= rx_word;
                    W_CHECKSUM:    shChecksum      <= rx_word;
`endif
                    default: ;
                endcase
            end

            if (publish) begin
                fPacketType    <= shType;
                fSourceID      <= shSourceID;
                fDestinationID <= shDestinationID;
                fSourceHops    <= shSourceHops;
                fQValue        <= shQValue;
                fEnergyLeft    <= shEnergyLeft;
                fHopsFromCH    <= shHopsFromCH;
                fChosenCH      <= commitChosenCH;
                iAmDestination <= isForMe(shDestinationID, myNodeID);
                pkt_valid      <= 1'b1;
            end else if (ackTaken) begin
                pkt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_packet_rx_parser.sv
// tb/tb_packet_rx_parser.sv - scoreboard bench for packet_rx_parser
module tb_packet_rx_parser;

`ifdef PKT_CHECKSUM_EN
    localparam int NW   = 9;
    localparam int CLAT = 2;
`else
    localparam int NW   = 8;
    localparam int CLAT = 1;
`endif

    localparam logic [114:0] RESET_F = {3'b111, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                        16'h0000, 16'h0000, 16'hFFFF, 16'h0000};

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [15:0] rx_word = 16'h0;
    logic        rx_valid = 1'b0;
    logic        rx_last = 1'b0;
    logic        rx_ready;
    logic [15:0] myNodeID = 16'h000C;
    logic [2:0]  fPacketType;
    logic [15:0] fSourceID, fDestinationID, fSourceHops, fQValue;
    logic [15:0] fEnergyLeft, fHopsFromCH, fChosenCH;
    logic        iAmDestination, pkt_valid, pkt_drop;
    logic        pkt_ack = 1'b0;

    always #5 clk = ~clk;

    packet_rx_parser dut (
        .clk            (clk),
        .nrst           (nrst),
        .rx_word        (rx_word),
        .rx_valid       (rx_valid),
        .rx_last        (rx_last),
        .rx_ready       (rx_ready),
        .myNodeID       (myNodeID),
        .fPacketType    (fPacketType),
        .fSourceID      (fSourceID),
        .fDestinationID (fDestinationID),
        .fSourceHops    (fSourceHops),
        .fQValue        (fQValue),
        .fEnergyLeft    (fEnergyLeft),
        .fHopsFromCH    (fHopsFromCH),
        .fChosenCH      (fChosenCH),
        .iAmDestination (iAmDestination),
        .pkt_valid      (pkt_valid),
        .pkt_ack        (pkt_ack),
        .pkt_drop       (pkt_drop)
    );

    wire [114:0] dutF = {fPacketType, fSourceID, fDestinationID, fSourceHops,
                         fQValue, fEnergyLeft, fHopsFromCH, fChosenCH};

    typedef struct {
        bit           isDrop;
        logic [114:0] f;
        bit           iam;
        int           cyc;
    } exp_t;

    exp_t         expQ[$];
    exp_t         holdExp;
    logic [114:0] modelF = RESET_F;
    bit           modelIam = 1'b0;
    logic [15:0]  words[16];
    int           nVec = 0;
    int           nErr = 0;
    int           negCnt = 0;
    bit           prevValid = 1'b0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic setWords(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                            input logic [15:0] w3, input logic [15:0] w4, input logic [15:0] w5,
                            input logic [15:0] w6, input logic [15:0] w7);
        words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
        words[4] = w4; words[5] = w5; words[6] = w6; words[7] = w7;
        words[8] = w0 ^ w1 ^ w2 ^ w3 ^ w4 ^ w5 ^ w6 ^ w7;
    endtask

    // kind: 0 = no outcome expected, 1 = good packet, 2 = drop
    task automatic sendPkt(input int n, input int lastIdx, input int kind, input int lat);
        int   stalls;
        exp_t e;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            rx_word  = words[i];
            rx_valid = 1'b1;
            rx_last  = (i == lastIdx);
            for (int k = 0; k < 20 && !rx_ready; k++) begin
                @(negedge clk);
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        chk("no_stall", stalls, 0);
        if (kind == 1) begin
            modelF   = {words[0][15:13], words[1], words[2], words[3], words[4],
                        words[5], words[6], words[7]};
            modelIam = (words[2] == myNodeID) || (words[2] == 16'hFFFF);
        end
        if (kind != 0) begin
            e.isDrop = (kind == 2);
            e.f      = modelF;
            e.iam    = modelIam;
            e.cyc    = negCnt + lat;
            expQ.push_back(e);
        end
    endtask

    task automatic waitAck(input int hold);
        for (int k = 0; k < 20 && !pkt_valid; k++) @(negedge clk);
        chk("valid_seen", pkt_valid, 1);
        repeat (hold) @(negedge clk);
        pkt_ack = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;
        chk("valid_cleared", pkt_valid, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        negCnt++;
        if (nrst) begin
            if (pkt_drop || (pkt_valid && !prevValid)) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_event", {pkt_drop, pkt_valid}, 2'b00);
                end else begin
                    e = expQ.pop_front();
                    chk("event_kind", {pkt_drop, pkt_valid}, e.isDrop ? 2'b10 : 2'b01);
                    chk("event_cycle", negCnt, e.cyc);
                    chk("fields", dutF, e.f);
                    chk("iam", iAmDestination, e.iam);
                    if (!e.isDrop) holdExp = e;
                end
            end else if (pkt_valid) begin
                chk("hold_fields", dutF, holdExp.f);
                chk("hold_ready", rx_ready, 0);
            end
        end
        prevValid = pkt_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_fields", dutF, RESET_F);
        chk("rst_iam", iAmDestination, 0);
        chk("rst_valid", pkt_valid, 0);
        chk("rst_drop", pkt_drop, 0);
        chk("rst_ready", rx_ready, 0);
        nrst = 1'b1;
        @(negedge clk);
        chk("idle_ready", rx_ready, 1);

        // Ack outside hold must do nothing.
        pkt_ack = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;

        // Heartbeat to this node.
        setWords(16'h1ABC, 16'h0000, 16'h000C, 16'h0002, 16'h1234, 16'h0050, 16'h0003, 16'h0009);
        sendPkt(NW, NW - 1, 1, CLAT);
        waitAck(2);
        chk("A_iam", iAmDestination, 1);
        chk("A_src", fSourceID, 16'h0000);

        // Broadcast invitation, held for several cycles.
        setWords(16'h4123, 16'h0017, 16'hFFFF, 16'h0001, 16'h3000, 16'h0064, 16'h0002, 16'h0017);
        sendPkt(NW, NW - 1, 1, CLAT);
        waitAck(5);
        chk("B_type", fPacketType, 3'b010);
        chk("B_qvalue", fQValue, 16'h3000);

        // Early rx_last on w4.
        setWords(16'h0000, 16'h0031, 16'h000C, 16'h0004, 16'h0777, 16'h0001, 16'h0001, 16'h0031);
        sendPkt(5, 4, 2, 1);
        repeat (3) @(negedge clk);
        chk("C_kept_q", fQValue, 16'h3000);

        // Clean packet not for us.
        setWords(16'h0000, 16'h0021, 16'h0005, 16'h0003, 16'h0100, 16'h0200, 16'h0001, 16'h0021);
        sendPkt(NW, NW - 1, 1, CLAT);
        waitAck(1);
        chk("D_iam", iAmDestination, 0);

        // Missing rx_last on final word; three extra words to flush.
        setWords(16'h4000, 16'h0055, 16'h000C, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005);
        words[NW] = 16'hAAAA; words[NW + 1] = 16'h5555; words[NW + 2] = 16'h1111;
        sendPkt(NW + 3, NW + 2, 2, 1);
        repeat (3) @(negedge clk);

        // Invalid type.
        setWords(16'hE000, 16'h0044, 16'h000C, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005);
        sendPkt(NW, NW - 1, 2, CLAT);
        repeat (3) @(negedge clk);
        chk("F_type_kept", fPacketType, 3'b000);

        // rx_last on the header word.
        setWords(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        sendPkt(1, 0, 2, 1);
        repeat (3) @(negedge clk);

`ifdef PKT_CHECKSUM_EN
        setWords(16'h0000, 16'h0066, 16'h000C, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005);
        words[8] = words[8] ^ 16'h0100;
        sendPkt(NW, NW - 1, 2, CLAT);
        repeat (3) @(negedge clk);
`endif

        // Reset after w3.
        setWords(16'h4000, 16'h0099, 16'h000C, 16'h0007, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        sendPkt(4, -1, 0, 0);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("mid_rst_fields", dutF, RESET_F);
        chk("mid_rst_iam", iAmDestination, 0);
        chk("mid_rst_valid", pkt_valid, 0);
        chk("mid_rst_drop", pkt_drop, 0);
        chk("mid_rst_ready", rx_ready, 0);
        modelF   = RESET_F;
        modelIam = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        setWords(16'h1ABC, 16'h0000, 16'h000C, 16'h0002, 16'h1234, 16'h0050, 16'h0003, 16'h0009);
        sendPkt(NW, NW - 1, 1, CLAT);
        waitAck(1);

        repeat (3) @(negedge clk);
        chk("queue_empty", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
